// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by uart_tx and uart_rx.
//   - uart_state_e : FSM state encoding, identical on both sides of the link
//   - DATA_BITS    : data bits per frame
//   - even_parity  : parity helper for the optional 8E1 frame format
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_START   = 3'b001,
      ST_DATA    = 3'b010,
      ST_STOP    = 3'b011,
      ST_CLEANUP = 3'b100,
      ST_PARITY  = 3'b101
   } uart_state_e;

   localparam int unsigned DATA_BITS    = 8;
   localparam logic [2:0]  LAST_BIT_IDX = 3'(DATA_BITS - 1);

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count so the FSM can advance to the next bit.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : forces the count to 0 (held while the FSM is not timing a bit)
//   enable : count while high
//   tick   : one-cycle pulse on the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;

   // tick stays combinational on purpose: it is internal only, and the FSM must
   // see it during the last cycle of the bit so the next bit starts on time.
   assign tick = enable && (cnt_r == LAST_CNT);

   // Bit-period counter; the reload on tick keeps it from ever wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clear || tick) begin
         cnt_r <= '0;
      end else if (enable) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: sends one byte per accepted tx_start as an 8N1 frame
// (8E1 when UART_TX_PARITY_EN is defined), LSB first, CLKS_PER_BIT clocks per
// bit. The line idles high.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   tx_start  : transmit request, only sampled while idle
//   tx_byte   : byte to send, captured when tx_start is accepted
//   tx_serial : serial TX line (registered)
//   tx_busy   : high for every state except IDLE (registered)
//   tx_done   : one-cycle pulse after the stop bit (registered)
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   uart_state_e state_r, state_s;
   logic [2:0]  bit_idx_r, bit_idx_s;
   logic [7:0]  shift_r, shift_s;
   logic        tx_serial_r, tx_busy_r, tx_done_r;
   logic        serial_s, busy_s, done_s;
   logic        tick_s, baud_en_s, baud_clear_s;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (baud_clear_s),
      .enable (baud_en_s),
      .tick   (tick_s)
   );

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_s   = state_r;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      baud_en_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            bit_idx_s = 3'd0;
            if (tx_start) begin
               shift_s = tx_byte;
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            baud_en_s = 1'b1;
            if (tick_s) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            baud_en_s = 1'b1;
            if (tick_s && (bit_idx_r == LAST_BIT_IDX)) begin
               bit_idx_s = 3'd0;
`ifdef UART_TX_PARITY_EN
               state_s   = ST_PARITY;
`else
               state_s   = ST_STOP;
`endif
            end else if (tick_s) begin
               bit_idx_s = bit_idx_r + 3'd1;
            end else begin
               bit_idx_s = bit_idx_r;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            baud_en_s = 1'b1;
            if (tick_s) begin
               state_s = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            baud_en_s = 1'b1;
            if (tick_s) begin
               state_s = ST_CLEANUP;
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_CLEANUP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s   = ST_IDLE;
            bit_idx_s = 3'd0;
         end
      endcase

      baud_clear_s = !baud_en_s;

      // Outputs are decoded from the next state so the registered line changes
      // on the same edge as the state, with no extra cycle of latency.
      case (state_s)
         ST_START:  serial_s = 1'b0;
         ST_DATA:   serial_s = shift_s[bit_idx_s];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: serial_s = even_parity(shift_s);
`endif
         ST_IDLE:   serial_s = 1'b1;
         ST_STOP:   serial_s = 1'b1;
         ST_CLEANUP: serial_s = 1'b1;
         default:   serial_s = 1'b1;
      endcase
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_CLEANUP);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'h00;
         tx_serial_r <= 1'b1;
         tx_busy_r   <= 1'b0;
         tx_done_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         bit_idx_r   <= bit_idx_s;
         shift_r     <= shift_s;
         tx_serial_r <= serial_s;
         tx_busy_r   <= busy_s;
         tx_done_r   <= done_s;
      end
   end

   assign tx_serial = tx_serial_r;
   assign tx_busy   = tx_busy_r;
   assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Expected line activity is built from the
// frame format itself: a list of frame bits, each held N cycles, followed by
// one cleanup cycle with tx_done high, then idle-high.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * N + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_serial, tx_busy, tx_done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] data;
      int         junk_cycle;
      logic [7:0] junk_byte;
      string      name;
   } vec_t;

   vec_t vecs[7];

   uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_start  (tx_start),
      .tx_byte   (tx_byte),
      .tx_serial (tx_serial),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   // Bit idx of a frame: 0 = start, 1..8 = data LSB first, then parity, stop.
   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      int cnt;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (FRAME_BITS == 11 && idx == 9) begin
         cnt = 0;
         for (int i = 0; i < 8; i++) cnt += int'(d[i]);
         return (cnt % 2) != 0;
      end
      return 1'b1;
   endfunction

   // Expected {serial,busy,done} for cycle c (1-based) after acceptance.
   function automatic logic [2:0] exp_frame(input logic [7:0] d, input int c);
      if (c == FRAME_CYC) return 3'b111;
      return {frame_bit(d, (c - 1) / N), 1'b1, 1'b0};
   endfunction

   // Called at a negedge with tx_start already high; checks the whole frame.
   task automatic check_frame(input logic [7:0] d, input string name,
                              input int junk_cycle, input logic [7:0] junk_byte);
      int bad_c;
      logic [2:0] got, want, bad_got, bad_want;
      bad_c = 0;
      bad_got = 3'b000;
      bad_want = 3'b000;
      for (int c = 1; c <= FRAME_CYC; c++) begin
         @(negedge clk);
         got  = {tx_serial, tx_busy, tx_done};
         want = exp_frame(d, c);
         if (got !== want && bad_c == 0) begin
            bad_c = c; bad_got = got; bad_want = want;
         end
         if (c == 1) tx_start = 1'b0;
         if (junk_cycle > 0 && c == junk_cycle) begin
            tx_start = 1'b1;
            tx_byte  = junk_byte;
         end
         if (junk_cycle > 0 && c == junk_cycle + N) tx_start = 1'b0;
      end
      tests++;
      if (bad_c != 0) begin
         fails++;
         $display("FAIL %s: cycle %0d {serial,busy,done}=%b, expected %b",
                  name, bad_c, bad_got, bad_want);
      end
   endtask

   task automatic check_idle(input int cycles, input string name);
      int bad_c;
      logic [2:0] got, bad_got;
      bad_c = 0;
      bad_got = 3'b000;
      for (int c = 1; c <= cycles; c++) begin
         @(negedge clk);
         got = {tx_serial, tx_busy, tx_done};
         if (got !== 3'b100 && bad_c == 0) begin
            bad_c = c; bad_got = got;
         end
      end
      tests++;
      if (bad_c != 0) begin
         fails++;
         $display("FAIL %s: idle cycle %0d {serial,busy,done}=%b, expected 100",
                  name, bad_c, bad_got);
      end
   endtask

   task automatic check_now(input string name, input logic [2:0] want);
      logic [2:0] got;
      got = {tx_serial, tx_busy, tx_done};
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: {serial,busy,done}=%b, expected %b", name, got, want);
      end
   endtask

   initial begin
      logic [7:0] d, jb;
      int         jc, gap;
      logic [7:0] b2b[4];
      int         bad_c;
      logic [2:0] got, want, bad_got, bad_want;

      vecs[0] = '{8'hA5, 0,  8'h00, "frame_a5"};
      vecs[1] = '{8'h00, 0,  8'h00, "frame_00"};
      vecs[2] = '{8'hFF, 0,  8'h00, "frame_ff"};
      vecs[3] = '{8'h55, 0,  8'h00, "frame_55"};
      vecs[4] = '{8'h80, 0,  8'h00, "frame_80"};
      vecs[5] = '{8'h07, 0,  8'h00, "frame_07"};
      vecs[6] = '{8'hA5, 10, 8'h3C, "midframe_start_ignored"};

      // Reset state while held in reset, and just after release.
      repeat (3) @(negedge clk);
      check_now("reset_state", 3'b100);
      rst_n = 1'b1;
      check_idle(2 * N, "idle_after_reset");

      // Table-driven frames.
      for (int v = 0; v < 7; v++) begin
         tx_byte  = vecs[v].data;
         tx_start = 1'b1;
         check_frame(vecs[v].data, vecs[v].name, vecs[v].junk_cycle, vecs[v].junk_byte);
         check_idle(3 * N, {vecs[v].name, "_idle"});
      end

      // Randomized frames with random gaps and random mid-frame junk requests.
      for (int r = 0; r < 8; r++) begin
         gap = $urandom_range(0, 5);
         repeat (gap) @(negedge clk);
         d  = 8'($urandom);
         jb = 8'($urandom);
         jc = ($urandom_range(0, 1) == 1) ? $urandom_range(2, FRAME_CYC - N - 1) : 0;
         tx_byte  = d;
         tx_start = 1'b1;
         check_frame(d, "random_frame", jc, jb);
         check_idle(2 * N, "random_idle");
      end

      // Back-to-back with tx_start held high: one idle cycle after cleanup.
      b2b[0] = 8'h3C; b2b[1] = 8'hC3; b2b[2] = 8'h01; b2b[3] = 8'hFE;
      tx_byte  = b2b[0];
      tx_start = 1'b1;
      bad_c = 0;
      bad_got = 3'b000;
      bad_want = 3'b000;
      for (int f = 0; f < 3; f++) begin
         for (int c = 1; c <= FRAME_CYC + 1; c++) begin
            @(negedge clk);
            got  = {tx_serial, tx_busy, tx_done};
            want = (c <= FRAME_CYC) ? exp_frame(b2b[f], c) : 3'b100;
            if (got !== want && bad_c == 0) begin
               bad_c = f * (FRAME_CYC + 1) + c; bad_got = got; bad_want = want;
            end
            if (c == 5) tx_byte = b2b[f+1];
            if (f == 2 && c == FRAME_CYC + 1) tx_start = 1'b0;
         end
      end
      tests++;
      if (bad_c != 0) begin
         fails++;
         $display("FAIL back_to_back: cycle %0d {serial,busy,done}=%b, expected %b",
                  bad_c, bad_got, bad_want);
      end
      check_idle(3 * N, "back_to_back_tail");

      // Reset asserted during data bit 3: outputs go to reset values at once.
      tx_byte  = 8'hC3;
      tx_start = 1'b1;
      for (int c = 1; c <= 4 * N + 2; c++) begin
         @(negedge clk);
         if (c == 1) tx_start = 1'b0;
      end
      check_now("before_midframe_reset", {frame_bit(8'hC3, 4), 2'b10});
      #1 rst_n = 1'b0;
      #1 check_now("async_reset_midframe", 3'b100);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle(3 * FRAME_BITS * N, "quiet_after_reset");

      tx_byte  = 8'h96;
      tx_start = 1'b1;
      check_frame(8'h96, "frame_after_reset", 0, 8'h00);
      check_idle(2 * N, "final_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
